// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first over WIDTH cycles.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clkout,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             load,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] LAST = (WIDTH)'(WIDTH - 1);

  state_t           state;
  state_t           nstate;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] cnt;
  logic             br;
  logic             d;
  logic             nbr;
  logic             last;
  logic             start;

  assign d     = ra[0] ^ rb[0] ^ br;
  assign nbr   = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
  assign last  = (cnt == LAST);
  assign start = (state == IDLE) && load;

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    nstate = load ? BUSY : IDLE;
      BUSY:    nstate = last ? DONE : BUSY;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Operands shift right so bit 0 is always the current column.
  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      ra   <= '0;
      rb   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (start) begin
      ra   <= a;
      rb   <= b;
      br   <= bin;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (state == BUSY) begin
      ra   <= ra >> 1;
      rb   <= rb >> 1;
      br   <= nbr;
      cnt  <= cnt + 1'b1;
      diff <= {d, diff[WIDTH-1:1]};
      if (last) begin
        bout <= nbr;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Borrow into the MSB column is br while the last bit is processed.
  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (start) begin
      ovf <= 1'b0;
    end else if ((state == BUSY) && last) begin
      ovf <= br ^ nbr;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results,
// a monitor pops and compares them on every done strobe.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam int M = (1 << W) - 1;

  logic         clkout = 1'b0;
  logic         rst    = 1'b0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic         bin    = 1'b0;
  logic         load   = 1'b0;
  logic         ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clkout(clkout),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .load  (load),
    .ready (ready),
    .diff  (diff),
    .bout  (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .done  (done)
  );

  always #5 clkout = ~clkout;

  typedef struct {
    int d;
    int bo;
    int ov;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t me;
  exp_t last_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   hold  = 0;

  always @(posedge clkout) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int av, input int bv, input int bi);
    exp_t e;
    int   r;
    int   sa;
    int   sb;
    int   sr;
    r    = av - bv - bi;
    sa   = (av > M / 2) ? av - (M + 1) : av;
    sb   = (bv > M / 2) ? bv - (M + 1) : bv;
    sr   = sa - sb - bi;
    e.d  = r & M;
    e.bo = (av < bv + bi) ? 1 : 0;
    e.ov = (sr < -((M + 1) / 2) || sr > M / 2) ? 1 : 0;
    e.due = 0;
    return e;
  endfunction

  task automatic cycle(input bit ld, input int av, input int bv, input int bi);
    bit   acc;
    exp_t e;
    int   ma;
    int   mb;
    @(negedge clkout);
    ma   = av & M;
    mb   = bv & M;
    load = ld;
    a    = ma[W-1:0];
    b    = mb[W-1:0];
    bin  = bi[0];
    acc  = ready && ld && rst;
    @(posedge clkout);
    #1;
    if (acc) begin
      e     = model(ma, mb, bi & 1);
      e.due = cyc + W;
      q.push_back(e);
    end
  endtask

  task automatic run_op(input int av, input int bv, input int bi);
    cycle(1'b1, av, bv, bi);
    repeat (W + 2) cycle(1'b0, 0, 0, 0);
  endtask

  always @(negedge clkout) begin
    if (rst) begin
      if (hold) begin
        chk("hold_diff", diff, last_e.d);
        chk("hold_bout", bout, last_e.bo);
        hold = 0;
      end
      if (done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got done=1 required no pending op");
        end else begin
          me = q.pop_front();
          chk("diff", diff, me.d);
          chk("bout", bout, me.bo);
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", ovf, me.ov);
`endif
          chk("latency", cyc, me.due);
          last_e = me;
          hold   = 1;
        end
      end
    end else begin
      hold = 0;
    end
  end

  initial begin
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clkout);
    rst = 1'b1;

    run_op(9, 3, 0);
    run_op(3, 9, 0);
    run_op(0, 0, 1);
    run_op(5, 5, 0);
    run_op(8, 1, 0);
    run_op(7, 1, 0);
    run_op(15, 15, 1);

    // Inputs and load wiggled while busy must not disturb the result.
    cycle(1'b1, 9, 3, 0);
    for (int i = 0; i <= W; i++) begin
      chk("ready_busy", ready, 0);
      cycle(1'b1, $urandom, $urandom, $urandom);
    end
    chk("ready_idle", ready, 1);
    repeat (W + 2) cycle(1'b0, 0, 0, 0);

    // Mid-operation reset.
    cycle(1'b1, 12, 5, 1);
    cycle(1'b0, 0, 0, 0);
    cycle(1'b0, 0, 0, 0);
    @(negedge clkout);
    rst = 1'b0;
    #1;
    chk("mrst_ready", ready, 1);
    chk("mrst_done", done, 0);
    chk("mrst_diff", diff, 0);
    chk("mrst_bout", bout, 0);
    q.delete(q.size() - 1);
    @(negedge clkout);
    rst = 1'b1;
    run_op(12, 5, 1);

    repeat (30) begin
      repeat ($urandom_range(0, 3)) cycle(1'b0, 0, 0, 0);
      run_op($urandom, $urandom, $urandom);
    end

    // Load held high: back-to-back restarts.
    repeat (3 * (W + 2) + 1) cycle(1'b1, $urandom, $urandom, $urandom);
    repeat (W + 3) cycle(1'b0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, 0, 0, 0);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
